// File: rtl/qrs_interval_scheduler_if.sv
// Counter bus between the QRS interval scheduler and its external sample
// counter. The scheduler drives restart/load controls; the counter returns
// its current value.
`timescale 1ns/1ps
interface qrs_interval_scheduler_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] counter_val;
  logic                  cnt_start;
  logic                  cnt_load;
  logic [DATA_WIDTH-1:0] cnt_value;

  modport master (
    input  counter_val,
    output cnt_start,
    output cnt_load,
    output cnt_value
  );

  modport slave (
    output counter_val,
    input  cnt_start,
    input  cnt_load,
    input  cnt_value
  );
endinterface

// File: rtl/qrs_interval_scheduler.sv
// Beat-to-beat timing controller for the Pan-Tompkins QRS detector.
// Restarts the external sample counter on every accepted beat, captures the
// RR interval, times the refractory and T-wave windows, requests a
// search-back once the interval exceeds ~166% of the RR average, flags lost
// beats, and keeps an 8-beat running RR average.
`timescale 1ns/1ps
module qrs_interval_scheduler #(
  parameter int DATA_WIDTH  = 16,
  parameter int REFRACT_CNT = 40,
  parameter int TWAVE_CNT   = 72,
  parameter int RR_INIT     = 160,
  parameter int MAX_RR      = 400
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      qrs_det,
  input  logic                      sb_done,
  qrs_interval_scheduler_if.master  cnt_bus,
  output logic                      qrs_accept,
  output logic                      in_refractory,
  output logic                      twave_check,
  output logic                      searchback_req,
  output logic                      beat_timeout,
  output logic                      rr_valid,
  output logic [DATA_WIDTH-1:0]     rr_interval,
  output logic [DATA_WIDTH-1:0]     rr_avg
);

  localparam int SW = DATA_WIDTH + 3;
  localparam logic [DATA_WIDTH-1:0] REFRACT_V = DATA_WIDTH'(REFRACT_CNT);
  localparam logic [DATA_WIDTH-1:0] TWAVE_V   = DATA_WIDTH'(TWAVE_CNT);
  localparam logic [DATA_WIDTH-1:0] MAX_V     = DATA_WIDTH'(MAX_RR);
  localparam logic [DATA_WIDTH-1:0] INIT_V    = DATA_WIDTH'(RR_INIT);
  localparam logic [SW-1:0]         SUM_INIT  = SW'(8 * RR_INIT);

  typedef enum logic [2:0] {
    IDLE,
    REFRACT,
    TWAVE,
    SEARCH,
    SB_WAIT
  } state_t;

  state_t state, state_nxt;

  logic                  sb_armed, sb_armed_nxt;
  logic                  cnt_start_q;
  logic [DATA_WIDTH-1:0] hist [8];
  logic [SW-1:0]         sum;

  logic                  accept, capture, sb_fire, timeout, cmp_ok;
  logic [DATA_WIDTH-1:0] cv;
  logic [DATA_WIDTH:0]   avg_ext, sb_sum;
  logic [DATA_WIDTH-1:0] sb_limit;

  assign cv     = cnt_bus.counter_val;
  assign rr_avg = sum[SW-1:3];

  assign cnt_bus.cnt_start = cnt_start_q;
  assign cnt_bus.cnt_load  = 1'b0;
  assign cnt_bus.cnt_value = '0;

  // Search-back limit ~1.66 x average, widened one bit then capped at MAX_RR
  always_comb begin
    avg_ext  = {1'b0, rr_avg};
    sb_sum   = avg_ext + (avg_ext >> 1) + (avg_ext >> 3) + (avg_ext >> 5);
    sb_limit = (sb_sum > {1'b0, MAX_V}) ? MAX_V : sb_sum[DATA_WIDTH-1:0];
  end

  // Next-state and event decode; counter compares are skipped while the restart strobe is out
  always_comb begin
    state_nxt    = state;
    sb_armed_nxt = sb_armed;
    accept       = 1'b0;
    capture      = 1'b0;
    sb_fire      = 1'b0;
    timeout      = 1'b0;
    cmp_ok       = !cnt_start_q;
    case (state)
      IDLE: begin
        if (qrs_det) accept = 1'b1;
      end
      REFRACT: begin
        if (cmp_ok && cv >= MAX_V)          timeout = 1'b1;
        else if (cmp_ok && cv >= REFRACT_V) state_nxt = TWAVE;
      end
      TWAVE: begin
        if (qrs_det) begin
          accept  = 1'b1;
          capture = 1'b1;
        end else if (cmp_ok && cv >= MAX_V) begin
          timeout = 1'b1;
        end else if (cmp_ok && cv >= TWAVE_V) begin
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (qrs_det) begin
          accept  = 1'b1;
          capture = 1'b1;
        end else if (cmp_ok && cv >= MAX_V) begin
          timeout = 1'b1;
        end else if (cmp_ok && sb_armed && cv >= sb_limit) begin
          sb_fire      = 1'b1;
          sb_armed_nxt = 1'b0;
          state_nxt    = SB_WAIT;
        end
      end
      SB_WAIT: begin
        if (qrs_det) begin
          accept  = 1'b1;
          capture = 1'b1;
        end else if (cmp_ok && cv >= MAX_V) begin
          timeout = 1'b1;
        end else if (sb_done) begin
          state_nxt = SEARCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      state_nxt    = REFRACT;
      sb_armed_nxt = 1'b1;
    end
    if (timeout) state_nxt = IDLE;
  end

  // State, strobes, window levels and RR history; everything freezes while en is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      sb_armed       <= 1'b1;
      cnt_start_q    <= 1'b0;
      qrs_accept     <= 1'b0;
      in_refractory  <= 1'b0;
      twave_check    <= 1'b0;
      searchback_req <= 1'b0;
      beat_timeout   <= 1'b0;
      rr_valid       <= 1'b0;
      rr_interval    <= '0;
      sum            <= SUM_INIT;
      for (int i = 0; i < 8; i++) hist[i] <= INIT_V;
    end else if (en) begin
      state          <= state_nxt;
      sb_armed       <= sb_armed_nxt;
      cnt_start_q    <= accept;
      qrs_accept     <= accept;
      rr_valid       <= capture;
      searchback_req <= sb_fire;
      beat_timeout   <= timeout;
      in_refractory  <= (state_nxt == REFRACT);
      twave_check    <= (state_nxt == TWAVE);
      if (capture) begin
        rr_interval <= cv;
        sum         <= sum - {3'b000, hist[7]} + {3'b000, cv};
        hist[0]     <= cv;
        for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
      end
    end
  end

endmodule

// File: tb/tb_qrs_interval_scheduler.sv
// Directed bench for qrs_interval_scheduler. A small behavioural counter
// answers the restart strobe so the scheduler sees realistic sample counts.
`timescale 1ns/1ps
module tb_qrs_interval_scheduler;

  logic        clk;
  logic        rst;
  logic        en;
  logic        qrs_det;
  logic        sb_done;
  logic        qrs_accept;
  logic        in_refractory;
  logic        twave_check;
  logic        searchback_req;
  logic        beat_timeout;
  logic        rr_valid;
  logic [15:0] rr_interval;
  logic [15:0] rr_avg;
  logic [15:0] cnt;

  int checks = 0;
  int errors = 0;

  qrs_interval_scheduler_if #(.DATA_WIDTH(16)) bus ();

  qrs_interval_scheduler #(
    .DATA_WIDTH (16),
    .REFRACT_CNT(40),
    .TWAVE_CNT  (72),
    .RR_INIT    (160),
    .MAX_RR     (400)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .qrs_det       (qrs_det),
    .sb_done       (sb_done),
    .cnt_bus       (bus),
    .qrs_accept    (qrs_accept),
    .in_refractory (in_refractory),
    .twave_check   (twave_check),
    .searchback_req(searchback_req),
    .beat_timeout  (beat_timeout),
    .rr_valid      (rr_valid),
    .rr_interval   (rr_interval),
    .rr_avg        (rr_avg)
  );

  // Clock generator
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External counter model: restarts to 1 on cnt_start, counts on en, reads 0 when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (en)            cnt <= bus.cnt_start ? 16'd1 : cnt + 16'd1;
  end
  assign bus.counter_val = en ? cnt : 16'd0;

  // Safety net in case the sequence stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge
  task automatic applyStimulus(input logic q, input logic s);
    qrs_det = q;
    sb_done = s;
    @(posedge clk);
    #1;
    qrs_det = 1'b0;
    sb_done = 1'b0;
  endtask

  task automatic runUntil(input int target, input string tag);
    int guard;
    guard = 0;
    while (int'(bus.counter_val) != target && guard < 1000) begin
      applyStimulus(1'b0, 1'b0);
      guard++;
    end
    checkOutput(tag, 32'(bus.counter_val), 32'(target));
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] pulses;
    logic       extra_req;

    rst     = 1'b1;
    en      = 1'b0;
    qrs_det = 1'b0;
    sb_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_qrs_accept", 32'(qrs_accept), 0);
    checkOutput("rst_in_refractory", 32'(in_refractory), 0);
    checkOutput("rst_twave_check", 32'(twave_check), 0);
    checkOutput("rst_searchback_req", 32'(searchback_req), 0);
    checkOutput("rst_beat_timeout", 32'(beat_timeout), 0);
    checkOutput("rst_rr_valid", 32'(rr_valid), 0);
    checkOutput("rst_rr_interval", 32'(rr_interval), 0);
    checkOutput("rst_rr_avg", 32'(rr_avg), 160);
    checkOutput("rst_cnt_start", 32'(bus.cnt_start), 0);
    checkOutput("rst_cnt_load", 32'(bus.cnt_load), 0);
    checkOutput("rst_cnt_value", 32'(bus.cnt_value), 0);

    rst = 1'b0;
    en  = 1'b1;

    $display("[TB] first beat from IDLE");
    applyStimulus(1'b1, 1'b0);
    checkOutput("idle_cnt_start", 32'(bus.cnt_start), 1);
    checkOutput("idle_qrs_accept", 32'(qrs_accept), 1);
    checkOutput("idle_in_refractory", 32'(in_refractory), 1);
    checkOutput("idle_rr_valid", 32'(rr_valid), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("idle_cnt_start_clear", 32'(bus.cnt_start), 0);
    checkOutput("idle_qrs_accept_clear", 32'(qrs_accept), 0);

    $display("[TB] refractory and T-wave windows");
    runUntil(20, "wait_20");
    applyStimulus(1'b1, 1'b0);
    checkOutput("refr_ignore_accept", 32'(qrs_accept), 0);
    checkOutput("refr_ignore_level", 32'(in_refractory), 1);
    runUntil(40, "wait_40");
    checkOutput("refr_still_at_40", 32'(in_refractory), 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("refr_fall", 32'(in_refractory), 0);
    checkOutput("twave_rise", 32'(twave_check), 1);
    runUntil(72, "wait_72");
    checkOutput("twave_still_at_72", 32'(twave_check), 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("twave_fall", 32'(twave_check), 0);
    runUntil(150, "wait_150");
    applyStimulus(1'b1, 1'b0);
    checkOutput("beat150_accept", 32'(qrs_accept), 1);
    checkOutput("beat150_rr_valid", 32'(rr_valid), 1);
    checkOutput("beat150_rr_interval", 32'(rr_interval), 150);
    checkOutput("beat150_rr_avg", 32'(rr_avg), 158);
    checkOutput("beat150_refr", 32'(in_refractory), 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("beat150_rr_valid_clear", 32'(rr_valid), 0);

    $display("[TB] search-back then timeout");
    doReset();
    applyStimulus(1'b1, 1'b0);
    runUntil(265, "wait_265");
    checkOutput("sb_not_before_265", 32'(searchback_req), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("sb_req_at_265", 32'(searchback_req), 1);
    checkOutput("sb_req_no_accept", 32'(qrs_accept), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("sb_req_one_cycle", 32'(searchback_req), 0);
    runUntil(300, "wait_300");
    applyStimulus(1'b0, 1'b1);
    extra_req = 1'b0;
    for (int i = 0; i < 1000 && bus.counter_val != 16'd400; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (searchback_req) extra_req = 1'b1;
    end
    checkOutput("sb_no_second_req", 32'(extra_req), 0);
    checkOutput("wait_400", 32'(bus.counter_val), 400);
    checkOutput("timeout_not_early", 32'(beat_timeout), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("timeout_pulse", 32'(beat_timeout), 1);
    checkOutput("timeout_rr_avg", 32'(rr_avg), 160);
    checkOutput("timeout_no_req", 32'(searchback_req), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("timeout_one_cycle", 32'(beat_timeout), 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("after_timeout_accept", 32'(qrs_accept), 1);
    checkOutput("after_timeout_no_rr", 32'(rr_valid), 0);

    $display("[TB] SB_WAIT collision");
    doReset();
    applyStimulus(1'b1, 1'b0);
    runUntil(265, "wait_265b");
    applyStimulus(1'b0, 1'b0);
    checkOutput("coll_sb_req", 32'(searchback_req), 1);
    runUntil(280, "wait_280");
    applyStimulus(1'b1, 1'b1);
    checkOutput("coll_accept", 32'(qrs_accept), 1);
    checkOutput("coll_rr_interval", 32'(rr_interval), 280);
    checkOutput("coll_rr_valid", 32'(rr_valid), 1);
    checkOutput("coll_refr", 32'(in_refractory), 1);
    checkOutput("coll_rr_avg", 32'(rr_avg), 175);

    $display("[TB] enable freeze mid-TWAVE");
    runUntil(50, "wait_50");
    checkOutput("freeze_pre_twave", 32'(twave_check), 1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i == 3, 1'b0);
      pulses = {bus.cnt_start, qrs_accept, rr_valid, searchback_req, beat_timeout};
      checkOutput("freeze_pulses", 32'(pulses), 0);
      checkOutput("freeze_twave", 32'(twave_check), 1);
    end
    en = 1'b1;
    checkOutput("freeze_rr_interval", 32'(rr_interval), 280);
    runUntil(72, "wait_72b");
    checkOutput("resume_twave_at_72", 32'(twave_check), 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("resume_twave_fall", 32'(twave_check), 0);

    $display("[TB] eight beats of 100 then reset");
    for (int b = 0; b < 8; b++) begin
      runUntil(100, "wait_100");
      applyStimulus(1'b1, 1'b0);
      checkOutput("beat100_accept", 32'(qrs_accept), 1);
    end
    checkOutput("beat100_rr_avg", 32'(rr_avg), 100);
    checkOutput("beat100_rr_interval", 32'(rr_interval), 100);
    runUntil(80, "wait_80");
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_rr_interval", 32'(rr_interval), 0);
    checkOutput("midrst_rr_avg", 32'(rr_avg), 160);
    checkOutput("midrst_refr", 32'(in_refractory), 0);
    checkOutput("midrst_twave", 32'(twave_check), 0);
    checkOutput("midrst_cnt_start", 32'(bus.cnt_start), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("midrst_idle_accept", 32'(qrs_accept), 1);
    checkOutput("midrst_idle_no_rr", 32'(rr_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qrs_interval_scheduler.md
Name: qrs_interval_scheduler

Overview:
- Sequences the sample-interval counter of the Pan-Tompkins QRS detector and owns all beat-to-beat timing decisions.
- On each confirmed QRS it restarts the counter and captures the RR interval.
- It also times the refractory and T-wave windows, issues a search-back request after 166% of the RR average, and maintains an 8-beat RR average.
- It sits between the decision/threshold logic and one external counter instance.

Parameters:
DATA_WIDTH, 16, width of counter value, intervals and average
REFRACT_CNT, 40, refractory length in samples (200 ms at 200 Hz)
TWAVE_CNT, 72, end of T-wave discrimination window (360 ms)
RR_INIT, 160, reset value of every RR history entry (800 ms)
MAX_RR, 400, lost-beat timeout in samples (2 s)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  sample-rate enable, shared with counter
qrs_det  in  1  confirmed-QRS pulse from decision logic
sb_done  in  1  pulse: search-back pass finished with no beat found
counter_val  in  DATA_WIDTH  current counter value (reads 0 when en low)
cnt_start  out  1  one-cycle restart strobe to counter (counter reads 1 afterwards)
cnt_load  out  1  tied 0; reserved
cnt_value  out  DATA_WIDTH  tied 0; reserved
qrs_accept  out  1  pulse: qrs_det accepted as a beat
in_refractory  out  1  high in REFRACT
twave_check  out  1  high in TWAVE
searchback_req  out  1  one-cycle search-back request
beat_timeout  out  1  one-cycle lost-beat pulse
rr_valid  out  1  one-cycle pulse: rr_interval updated
rr_interval  out  DATA_WIDTH  last captured RR interval
rr_avg  out  DATA_WIDTH  floor(sum of 8-entry history / 8)

Behaviour:
- Clock, reset and registered outputs:
  - Single clk domain.
  - rst asserts asynchronously and immediately forces: state IDLE; all pulse/level outputs 0; rr_interval 0; history entries = RR_INIT; sum = 8*RR_INIT; sb_armed 1.
  - All outputs are registered.
  - rr_avg is sum[DATA_WIDTH+2:3] taken from a DATA_WIDTH+3-bit sum register.
- en low:
  - All state and registers hold.
  - qrs_det and sb_done are ignored.
  - No pulses are generated; level outputs hold.
- States: IDLE, REFRACT, TWAVE, SEARCH, SB_WAIT.
- Accept event (qrs_det=1 and en=1, in state TWAVE, SEARCH or SB_WAIT), cycle T. At the edge ending T:
  - cnt_start=1, qrs_accept=1.
  - rr_interval<=counter_val and rr_valid=1.
  - History shifts in counter_val; sum <= sum - oldest + counter_val.
  - sb_armed<=1; state<=REFRACT.
- IDLE accept (qrs_det=1, en=1): cnt_start=1, qrs_accept=1, state REFRACT. No rr_valid; history unchanged.
- REFRACT:
  - qrs_det ignored.
  - Move to TWAVE when counter_val>=REFRACT_CNT.
  - The comparison is suppressed in the cycle cnt_start is high, because the counter still shows the stale value.
- TWAVE: move to SEARCH when counter_val>=TWAVE_CNT. Accept has priority over this transition.
- SEARCH, search-back limit:
  - sb_limit = avg + avg>>1 + avg>>3 + avg>>5, computed at DATA_WIDTH+1 bits and saturated to MAX_RR.
  - If sb_armed and counter_val>=sb_limit: searchback_req pulse, sb_armed<=0, state SB_WAIT.
  - Accept has priority.
- SB_WAIT:
  - sb_done returns to SEARCH with no new request.
  - qrs_det in the same cycle as sb_done: accept wins and sb_done is dropped.
- Timeout:
  - In REFRACT, TWAVE, SEARCH or SB_WAIT, counter_val>=MAX_RR with no accept gives a beat_timeout pulse and state IDLE.
  - History and average are preserved.
  - Suppressed while cnt_start is high.
- Wrap-around: the counter is never allowed to reach its PERIOD wrap, since MAX_RR must be less than PERIOD. Timeout takes precedence over searchback_req in the same cycle.
- Only one of qrs_accept, searchback_req and beat_timeout may pulse per cycle.

Test Plan:
- Reset and first beat:
  - Stimulus: rst pulse, then en=1 and qrs_det in IDLE.
  - Required: all outputs 0 and rr_avg=160 after reset; next cycle cnt_start=1, qrs_accept=1, in_refractory=1, rr_valid stays 0.
- Refractory and T-wave window:
  - Stimulus: qrs_det at counter_val=20, then qrs_det at counter_val=150.
  - Required: the first is ignored; in_refractory falls and twave_check rises at 40; at 150 rr_interval=150, rr_valid pulses, rr_avg=158.
- Search-back then timeout:
  - Stimulus: no beats after a beat; sb_done later; still no beat.
  - Required: searchback_req at counter_val=265 (avg 160); after sb_done state SEARCH with no second request; beat_timeout at 400, state IDLE, rr_avg unchanged.
- SB_WAIT collision:
  - Stimulus: qrs_det and sb_done in the same cycle at counter_val=280.
  - Required: qrs_accept=1, rr_interval=280, state REFRACT.
- Enable freeze:
  - Stimulus: en low for 10 cycles mid-TWAVE, with qrs_det pulsed during the gap.
  - Required: no pulses, twave_check held, state resumes unchanged.
- Reset mid-operation:
  - Stimulus: rst asserted in SEARCH after 8 beats of 100.
  - Required: immediate IDLE, outputs 0, rr_avg back to 160.
